// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer arbiter slice.
// The framebuffer holds a downscaled image; one entry covers a 2^SHIFT square of pixels.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned SHIFT    = 2;
  localparam int unsigned FB_W     = H_ACTIVE >> SHIFT;
  localparam int unsigned FB_H     = V_ACTIVE >> SHIFT;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned DATA_W   = 8;

  localparam logic [DATA_W-1:0] BG_COLOR = 8'h00;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_SCAN,
    OWN_HOST
  } owner_t;

  typedef enum logic {
    H_IDLE,
    H_RD
  } host_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Maps a screen coordinate to the linear framebuffer word address.
// Row stride is a constant, so the product is built from shifted adds of the row index.
module fb_addr_gen
  import vga_pkg::*;
(
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;

  always_comb begin
    row  = ADDR_W'(y >> SHIFT);
    col  = ADDR_W'(x >> SHIFT);
    addr = col;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      if (FB_W[i]) begin
        addr = addr + (row << i);
      end
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates one single-port framebuffer RAM between VGA scanout and a host port.
// Scanout owns every active-video pix_en cycle; the host gets all remaining cycles.
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [DATA_W-1:0] pix_color,
  output logic              frame_start,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [ADDR_W-1:0] scan_addr;
  logic              in_active;
  logic              scan_slot;
  owner_t            owner;
  logic              scan_q;
  logic              bg_q;
  host_state_t       h_state_q;
  host_state_t       h_state_d;

  fb_addr_gen u_addr_gen (
    .x    (x),
    .y    (y),
    .addr (scan_addr)
  );

  // Combinational outputs are held quiet while reset is asserted.
  always_comb begin
    in_active   = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
    scan_slot   = pix_en && in_active;
    host_gnt    = rst_n && !scan_slot && host_req;
    frame_start = rst_n && pix_en && (x == '0) && (y == 10'(V_ACTIVE));
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    owner       = OWN_NONE;
    if (rst_n) begin
      if (scan_slot) begin
        mem_addr = scan_addr;
        owner    = OWN_SCAN;
      end else if (host_req) begin
        mem_addr  = host_addr;
        mem_we    = host_we;
        mem_wdata = host_wdata;
        if (!host_we) begin
          owner = OWN_HOST;
        end
      end
    end
  end

  // Pixel pipeline: RAM data arrives one clk after the scan read and is latched
  // at the end of that clk, so pix_color updates one pixel after its pix_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q    <= 1'b0;
      bg_q      <= 1'b0;
      pix_color <= BG_COLOR;
    end else begin
      scan_q <= (owner == OWN_SCAN);
      bg_q   <= pix_en && !in_active;
      if (scan_q) begin
        pix_color <= mem_rdata;
      end else if (bg_q) begin
        pix_color <= BG_COLOR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_state_q <= H_IDLE;
    end else begin
      h_state_q <= h_state_d;
    end
  end

  // host_rdata forwards mem_rdata directly so it lines up with host_rvalid.
  always_comb begin
    h_state_d   = H_IDLE;
    host_rvalid = 1'b0;
    host_rdata  = '0;
    case (h_state_q)
      H_IDLE: ;
      H_RD: begin
        host_rvalid = 1'b1;
        host_rdata  = mem_rdata;
      end
      default: ;
    endcase
    if (owner == OWN_HOST) begin
      h_state_d = H_RD;
    end
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between two requesters: VGA scanout (pixel fetch) and a host port (game/drawing logic, read/write).
- Sits between vgaController (x, y, pixel strobe) and videoGen/colour lookup. Also drives the RAM port.
- Scanout has absolute priority in active video; the host gets every other cycle in active video and all cycles in blanking.
- Framebuffer stores a downscaled image: each stored entry covers a 2^SHIFT × 2^SHIFT pixel block.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- SHIFT, 2, log2 of scale factor (640x480 -> 160x120)
- ADDR_W, 15, RAM address width (must hold 160*120 = 19200)
- DATA_W, 8, pixel/colour-index width
- BG_COLOR, 8'h00, value output outside the active area

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  one-clk strobe at pixel rate (every 2nd clk); x/y valid on this cycle
- x  in  10  current pixel column from timing generator
- y  in  10  current pixel row from timing generator
- pix_color  out  DATA_W  colour for pixel sampled at previous pix_en
- frame_start  out  1  one-clk pulse when x=0, y=V_ACTIVE is sampled (start of vblank)
- host_req  in  1  host access request; held until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host word address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  one-clk pulse: request accepted (RAM access issued this cycle)
- host_rvalid  out  1  one-clk pulse: host_rdata valid (cycle after read grant)
- host_rdata  out  DATA_W  host read data
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency

Behaviour:
- Reset (async assert, sync release): pix_color=BG_COLOR; all other outputs 0; pipeline owner flags cleared. Any in-flight read is dropped, so no host_rvalid follows reset.
- Slot rule, combinational each cycle:
  - SCAN slot: pix_en=1 and x<H_ACTIVE and y<V_ACTIVE.
  - Otherwise the cycle is a HOST slot.
- SCAN slot:
  - mem_addr = (y>>SHIFT)*(H_ACTIVE>>SHIFT) + (x>>SHIFT), computed with shift-adds, no multiplier.
  - mem_we=0; host is not granted.
- HOST slot with host_req=1:
  - host_gnt=1; mem_addr=host_addr; mem_we=host_we; mem_wdata=host_wdata.
- HOST slot with host_req=0: mem_we=0.
- Owner pipeline: a 1-bit register records which requester issued a read (scan or host read).
  - Cycle after a scan read: pix_color <= mem_rdata.
  - Cycle after a host read grant: host_rdata <= mem_rdata (combinational capture OK, registered preferred); host_rvalid=1.
  - Writes produce no rvalid.
- pix_en with non-active x/y: pix_color <= BG_COLOR on the following cycle.
- pix_color changes only on the cycle after a pix_en. Latency is exactly one pixel; the integrator delays hsync/vsync/blank by one pixel to match.
- Host worst-case wait is 1 clk during active video, 0 during blanking.
- Host state machine:
  - H_IDLE -> H_RD (read granted) -> H_IDLE, asserting host_rvalid in H_RD.
  - Write grant stays in H_IDLE.
  - A new request may be granted in H_RD if the slot allows (back-to-back reads are pipelined).
- frame_start fires on the pix_en where x==0 and y==V_ACTIVE, once per frame.
- Out-of-range host_addr (>=19200) is passed through unchanged; the RAM wraps or ignores it. No error flag.
- pix_en held high continuously (illegal) starves the host during active video. This is not guarded, but pix_color must stay correct.

Decomposition:
- Package vga_pkg: H_ACTIVE, V_ACTIVE, FB_W=160, FB_H=120, SHIFT, DATA_W, ADDR_W, BG_COLOR, typedef enum owner_t {OWN_NONE, OWN_SCAN, OWN_HOST}.
- Sub-module fb_addr_gen: combinational (x, y) -> linear address, shift-add only. Separately testable.

Test Plan:
- Reset: assert rst_n=0 mid-frame with a host read in flight -> all outputs 0, pix_color=BG_COLOR, no host_rvalid after release.
- Scan fetch: preload RAM[0]=8'h12, RAM[161]=8'h34; drive x=0,y=0 then x=4,y=4 on pix_en -> mem_addr 0 then 161; pix_color 8'h12 then 8'h34, one pixel later.
- Contention: host_req=1 write addr 5 data 8'hAA, asserted on a pix_en cycle in active video -> no gnt that cycle; gnt on next clk with mem_we=1, mem_addr=5.
- Blanking: x=700, host reads addr 5 on consecutive clks -> gnt every clk, host_rvalid with 8'hAA one clk after each gnt; pix_color=BG_COLOR.
- Frame pulse: sweep full 800x525 timing -> exactly one frame_start per frame, at x=0,y=480.
- Full frame: random host writes during a frame -> scoreboard every pix_color against reference model (x>>2, y>>2 lookup); zero mismatches, no host request waits more than 1 clk.
